// File: rtl/ctrl_fsm.sv
// Multicycle control FSM: decodes Op/Funct/Rd and sequences the datapath one state per cycle.
// Latency: outputs are Moore (state) plus combinational instruction decode; LDR 5, STR 4, DP 4, B 3 cycles.
// Backpressure: none by default; with CTRL_FSM_MEMWAIT_EN, FETCH/MEMREAD/MEMWRITE hold while mem_ready=0.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset (forces FETCH)
//   mem_ready             memory handshake, present only when CTRL_FSM_MEMWAIT_EN is defined
//   Op, Funct, Rd         instruction fields [27:26], [25:20], destination register
//   PCS, RegW, MemW, FlagW  unconditioned requests into the conditional-logic block
//   IRWrite, NextPC, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc  datapath controls
//   state                 current state encoding, for debug
module ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
`ifdef CTRL_FSM_MEMWAIT_EN
  input  logic       mem_ready,
`endif
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;

  logic [3:0] state_q, state_d;
  logic       mem_ok;

  // Without the wait option every memory access completes in its own cycle.
`ifdef CTRL_FSM_MEMWAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = mem_ok ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;  // Op=11 is illegal: drop it with no side effects
        endcase
      end
      MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = mem_ok ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = mem_ok ? FETCH : MEMWRITE;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // Raw (ungated) Moore controls
  logic irw_raw, npc_raw, regw_raw, memw_raw, aluop, branch;
  logic add_or_sub, pcs_raw;
  logic [1:0] alu_cmd, flagw_raw;

  always_comb begin
    irw_raw   = 1'b0;
    npc_raw   = 1'b0;
    regw_raw  = 1'b0;
    memw_raw  = 1'b0;
    aluop     = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    case (state_q)
      FETCH: begin
        // The instruction is only captured once memory has delivered it.
        irw_raw   = mem_ok;
        npc_raw   = mem_ok;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        regw_raw  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        memw_raw = 1'b1;
      end
      EXECUTER: aluop = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        aluop   = 1'b1;
      end
      ALUWB:    regw_raw = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU command decode from Funct[4:1]; unknown commands fall back to ADD
  // but are not treated as ADD for the carry/overflow flag update.
  always_comb begin
    alu_cmd    = 2'b00;
    add_or_sub = 1'b0;
    case (Funct[4:1])
      4'b0100: begin alu_cmd = 2'b00; add_or_sub = 1'b1; end
      4'b0010: begin alu_cmd = 2'b01; add_or_sub = 1'b1; end
      4'b0000: alu_cmd = 2'b10;
      4'b1100: alu_cmd = 2'b11;
      default: alu_cmd = 2'b00;
    endcase
  end

  assign ALUControl = aluop ? alu_cmd : 2'b00;
  assign flagw_raw  = aluop ? {Funct[0], Funct[0] & add_or_sub} : 2'b00;
  assign pcs_raw    = (regw_raw & (Rd == 4'hF)) | branch;

  // Write strobes are suppressed for the whole reset window so that an
  // abandoned instruction cannot commit anything.
  assign IRWrite = irw_raw  & ~reset;
  assign NextPC  = npc_raw  & ~reset;
  assign RegW    = regw_raw & ~reset;
  assign MemW    = memw_raw & ~reset;
  assign PCS     = pcs_raw  & ~reset;
  assign FlagW   = reset ? 2'b00 : flagw_raw;

  assign ImmSrc  = Op;
  assign RegSrc  = {(Op == 2'b01), (Op == 2'b10)};
  assign state   = state_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
module tb_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_ready;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS, RegW, MemW, IRWrite, NextPC, AdrSrc;
  logic [1:0] FlagW, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  ctrl_fsm dut (
    .clk(clk), .reset(reset),
`ifdef CTRL_FSM_MEMWAIT_EN
    .mem_ready(mem_ready),
`endif
    .Op(Op), .Funct(Funct), .Rd(Rd),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .FlagW(FlagW),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .state(state)
  );

  always #5 clk = ~clk;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4;
  localparam int S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9;

  typedef struct {
    int st;
    int irw, npc, adr, regw, memw, pcs, flagw;
    int rsrc, srca, srcb, aluc, imms, regs;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Expected outputs for one cycle, read straight off the per-state table
  // plus the instruction-field rules.
  function automatic exp_t model_out(int st, logic [1:0] op, logic [5:0] f, logic [3:0] rd);
    exp_t e;
    bit dp;
    int cmd;
    bit arith;
    e.st   = st;
    e.irw  = (st == S_FETCH);
    e.npc  = (st == S_FETCH);
    e.adr  = (st == S_MEMREAD || st == S_MEMWRITE);
    e.regw = (st == S_MEMWB || st == S_ALUWB);
    e.memw = (st == S_MEMWRITE);
    e.srca = (st == S_FETCH || st == S_DECODE) ? 1 : 0;
    e.srcb = (st == S_FETCH || st == S_DECODE) ? 2 :
             (st == S_MEMADR || st == S_EXECI || st == S_BRANCH) ? 1 : 0;
    e.rsrc = (st == S_FETCH || st == S_DECODE || st == S_BRANCH) ? 2 :
             (st == S_MEMWB) ? 1 : 0;
    dp = (st == S_EXECR || st == S_EXECI);
    cmd = 0; arith = 0;
    if (f[4:1] == 4'b0100) begin cmd = 0; arith = 1; end
    else if (f[4:1] == 4'b0010) begin cmd = 1; arith = 1; end
    else if (f[4:1] == 4'b0000) cmd = 2;
    else if (f[4:1] == 4'b1100) cmd = 3;
    e.aluc  = dp ? cmd : 0;
    e.flagw = dp ? (int'(f[0]) * 2 + int'(f[0] & arith)) : 0;
    e.pcs   = ((e.regw != 0 && rd == 4'hF) || st == S_BRANCH) ? 1 : 0;
    e.imms  = int'(op);
    e.regs  = (op == 2'b01) ? 2 : (op == 2'b10) ? 1 : 0;
    return e;
  endfunction

  task automatic push_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                            output int len);
    int seq[$];
    seq.push_back(S_FETCH);
    seq.push_back(S_DECODE);
    case (op)
      2'b01: begin
        seq.push_back(S_MEMADR);
        if (f[0]) begin seq.push_back(S_MEMREAD); seq.push_back(S_MEMWB); end
        else seq.push_back(S_MEMWRITE);
      end
      2'b00: begin
        seq.push_back(f[5] ? S_EXECI : S_EXECR);
        seq.push_back(S_ALUWB);
      end
      2'b10: seq.push_back(S_BRANCH);
      default: ;
    endcase
    foreach (seq[i]) exp_q.push_back(model_out(seq[i], op, f, rd));
    len = seq.size();
  endtask

  // Single compare process: every cycle with a pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("state", int'(state), e.st);
      chk("IRWrite", int'(IRWrite), e.irw);
      chk("NextPC", int'(NextPC), e.npc);
      chk("AdrSrc", int'(AdrSrc), e.adr);
      chk("RegW", int'(RegW), e.regw);
      chk("MemW", int'(MemW), e.memw);
      chk("PCS", int'(PCS), e.pcs);
      chk("FlagW", int'(FlagW), e.flagw);
      chk("ResultSrc", int'(ResultSrc), e.rsrc);
      chk("ALUSrcA", int'(ALUSrcA), e.srca);
      chk("ALUSrcB", int'(ALUSrcB), e.srcb);
      chk("ALUControl", int'(ALUControl), e.aluc);
      chk("ImmSrc", int'(ImmSrc), e.imms);
      chk("RegSrc", int'(RegSrc), e.regs);
    end
  end

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 of the next FETCH.
  // Literal expectations at cycle lc pin the model on the instructions of interest.
  task automatic run(input string nm, input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                     input int lat, input int lc, input int fw, input int alu,
                     input int rw, input int mw, input int pc);
    int len;
    Op = op; Funct = f; Rd = rd;
    push_instr(op, f, rd, len);
    chk({nm, "_latency"}, len, lat);
    for (int i = 0; i < len; i++) begin
      if (i == lc) begin
        #2;
        chk({nm, "_lit_FlagW"}, int'(FlagW), fw);
        chk({nm, "_lit_ALUControl"}, int'(ALUControl), alu);
        chk({nm, "_lit_RegW"}, int'(RegW), rw);
        chk({nm, "_lit_MemW"}, int'(MemW), mw);
        chk({nm, "_lit_PCS"}, int'(PCS), pc);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1;
    Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
    #3;
    chk("rst_state", int'(state), 0);
    chk("rst_IRWrite", int'(IRWrite), 0);
    chk("rst_NextPC", int'(NextPC), 0);
    chk("rst_ALUSrcB", int'(ALUSrcB), 2);
    @(posedge clk); #1;
    chk("rst_state_held", int'(state), 0);
    reset = 1'b0;

    //   name    op     funct      rd   lat lc fw alu rw mw pcs
    run("adds",  2'b00, 6'b101001, 4'd3,  4, 2, 3, 0, 0, 0, 0);
    run("ldr",   2'b01, 6'b011001, 4'hF,  5, 4, 0, 0, 1, 0, 1);
    run("b",     2'b10, 6'b000000, 4'd0,  3, 2, 0, 0, 0, 0, 1);
    run("ands",  2'b00, 6'b000001, 4'd1,  4, 2, 2, 2, 0, 0, 0);
    run("ill",   2'b11, 6'b111111, 4'hF,  2, 1, 0, 0, 0, 0, 0);
    run("str",   2'b01, 6'b011000, 4'd2,  4, 3, 0, 0, 0, 1, 0);
    run("subs",  2'b00, 6'b000101, 4'hF,  4, 3, 0, 0, 1, 0, 1);
    run("orr",   2'b00, 6'b111000, 4'd4,  4, 2, 0, 3, 0, 0, 0);
    run("unk",   2'b00, 6'b010101, 4'd5,  4, 2, 2, 0, 0, 0, 0);

    // Reset pulse in the middle of an LDR.
    Op = 2'b01; Funct = 6'b011001; Rd = 4'hF;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_state_memread", int'(state), 3);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_IRWrite", int'(IRWrite), 0);
    chk("mid_rst_RegW", int'(RegW), 0);
    chk("mid_rst_PCS", int'(PCS), 0);
    chk("mid_rst_AdrSrc", int'(AdrSrc), 0);
    @(posedge clk); #1;
    chk("mid_rst_state_held", int'(state), 0);
    chk("mid_rst_NextPC_held", int'(NextPC), 0);
    Op = 2'b11;
    reset = 1'b0;
    #2;
    chk("post_rst_IRWrite", int'(IRWrite), 1);
    @(posedge clk); #1;
    chk("post_rst_decode", int'(state), 1);
    chk("post_rst_no_regw", int'(RegW), 0);
    @(posedge clk); #1;
    chk("post_rst_fetch", int'(state), 0);

`ifdef CTRL_FSM_MEMWAIT_EN
    // STR with mem_ready low for three MEMWRITE cycles.
    Op = 2'b01; Funct = 6'b011000; Rd = 4'd2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk("wait_state", int'(state), 5);
      chk("wait_MemW", int'(MemW), 1);
      if (i == 3) mem_ready = 1'b1;
      @(posedge clk); #1;
    end
    chk("wait_done_fetch", int'(state), 0);
`endif

    run("adds2", 2'b00, 6'b101001, 4'hF,  4, 3, 0, 0, 1, 0, 1);
    @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
